logic_unit_pipe: RTL and testbench



---
 rtl/logic_unit_pipe.sv | 131 +++++++++++++
 tb/tb_logic_unit_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with valid/ready handshakes and zero/parity/sign flags.
// Optional macro LOGIC_UNIT_OP_COUNT_EN adds a saturating 16-bit output-transfer counter.
module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             flag_zero,
  output logic             flag_par,
  output logic             flag_neg
`ifdef LOGIC_UNIT_OP_COUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("logic_unit_pipe: STAGES must be in 1..4");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("logic_unit_pipe: WIDTH must be >= 1");
  end

  function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0]       sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
    case (sel)
      3'b000:  return x | z;
      3'b001:  return x & z;
      3'b010:  return x ^ z;
      3'b011:  return ~(x | z);
      3'b100:  return ~(x & z);
      3'b101:  return ~(x ^ z);
      3'b110:  return ~x;
      default: return z;
    endcase
  endfunction

  // Packed as {neg, par, zero}.
  function automatic logic [2:0] result_flags(input logic [WIDTH-1:0] r);
    return {r[WIDTH-1], ^r, (r == '0)};
  endfunction

`ifdef LOGIC_UNIT_OP_COUNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction
`endif

  logic [WIDTH-1:0]  res_c;
  logic [2:0]        flg_c;
  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] vld_src;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  res_p   [STAGES];
  logic [WIDTH-1:0]  res_src [STAGES];
  logic [2:0]        flg_p   [STAGES];
  logic [2:0]        flg_src [STAGES];

  assign res_c = logic_fn(op, a, b);
  assign flg_c = result_flags(res_c);

  for (genvar g = 0; g < STAGES; g++) begin : g_src
    if (g == 0) begin : g_head
      assign vld_src[g] = in_valid;
      assign res_src[g] = res_c;
      assign flg_src[g] = flg_c;
    end else begin : g_body
      assign vld_src[g] = vld_p[g-1];
      assign res_src[g] = res_p[g-1];
      assign flg_src[g] = flg_p[g-1];
    end
  end

  // A stage moves unless it and every stage after it are full while the output stalls.
  always_comb begin : adv_comb
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      full   = full & vld_p[i];
      adv[i] = out_ready | ~full;
    end
  end

  // Stage registers: data loads only with a valid beat, so idle outputs hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p            <= '0;
      res_p[STAGES-1]  <= '0;
      flg_p[STAGES-1]  <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (adv[i]) begin
          vld_p[i] <= vld_src[i];
          if (vld_src[i]) begin
            res_p[i] <= res_src[i];
            flg_p[i] <= flg_src[i];
          end
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_p[STAGES-1];
  assign y         = res_p[STAGES-1];
  assign flag_neg  = flg_p[STAGES-1][2];
  assign flag_par  = flg_p[STAGES-1][1];
  assign flag_zero = flg_p[STAGES-1][0];

`ifdef LOGIC_UNIT_OP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= sat_inc(op_count);
    end
  end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: main 8-bit/2-stage instance plus 1-bit/1-stage and 32-bit/4-stage sweeps.
module tb_logic_unit_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Shared control
  logic rst;

  // Main instance: WIDTH=8, STAGES=2
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, y;
  logic [2:0] op;
  logic       fz, fp, fn;
  logic [2:0] mflg;
  assign mflg = {fn, fp, fz};
`ifdef LOGIC_UNIT_OP_COUNT_EN
  logic [15:0] cnt_m, cnt_1, cnt_4;
`endif

  logic_unit_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flag_zero(fz), .flag_par(fp), .flag_neg(fn)
`ifdef LOGIC_UNIT_OP_COUNT_EN
    , .op_count(cnt_m)
`endif
  );

  // Sweep instances share stimulus
  logic        sv, sready;
  logic [31:0] sa, sb;
  logic [2:0]  sop;
  logic        i1_ready, o1_valid, y1, z1, p1, n1;
  logic        i4_ready, o4_valid, z4, p4, n4;
  logic [31:0] y4;

  logic_unit_pipe #(.WIDTH(1), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(sv), .in_ready(i1_ready),
    .a(sa[0]), .b(sb[0]), .op(sop), .out_valid(o1_valid), .out_ready(sready),
    .y(y1), .flag_zero(z1), .flag_par(p1), .flag_neg(n1)
`ifdef LOGIC_UNIT_OP_COUNT_EN
    , .op_count(cnt_1)
`endif
  );

  logic_unit_pipe #(.WIDTH(32), .STAGES(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(sv), .in_ready(i4_ready),
    .a(sa), .b(sb), .op(sop), .out_valid(o4_valid), .out_ready(sready),
    .y(y4), .flag_zero(z4), .flag_par(p4), .flag_neg(n4)
`ifdef LOGIC_UNIT_OP_COUNT_EN
    , .op_count(cnt_4)
`endif
  );

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z);
    case (o)
      3'd0: return x | z;
      3'd1: return x & z;
      3'd2: return x ^ z;
      3'd3: return ~(x | z);
      3'd4: return ~(x & z);
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return z;
    endcase
  endfunction

  task automatic single_beat(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                             input logic [2:0] iop, input logic [7:0] ey, input logic [2:0] ef);
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; a = ia; b = ib; op = iop;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_vld_early"}, out_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, out_valid, 1);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_flags"}, mflg, ef);
  endtask

  localparam int N = 48;
  logic        hv  [N+5];
  logic [31:0] e32 [N+5];
  logic [2:0]  f32 [N+5];
  logic        e1  [N+5];
  logic [2:0]  f1  [N+5];
  int          xfer1, xfer4;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    sv = 1'b0; sready = 1'b1; sa = '0; sb = '0; sop = '0;
    xfer1 = 0; xfer4 = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_flags", mflg, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // Single beats, flags {neg,par,zero}
    single_beat("or",   8'hF0, 8'h3C, 3'b000, 8'hFC, 3'b100);
    single_beat("and",  8'hF0, 8'h3C, 3'b001, 8'h30, 3'b000);
    single_beat("xor",  8'hF0, 8'h3C, 3'b010, 8'hCC, 3'b100);
    single_beat("nor",  8'hF0, 8'h3C, 3'b011, 8'h03, 3'b000);
    single_beat("zero", 8'h0F, 8'hF0, 3'b001, 8'h00, 3'b001);
    single_beat("par",  8'h01, 8'h00, 3'b000, 8'h01, 3'b010);

    // Back-to-back: a=k ^ b=A0 -> A0..A4 on consecutive cycles
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n < 5) chk("b2b_in_ready", in_ready, 1);
      if (n < 2 || n == 7) chk("b2b_vld_idle", out_valid, 0);
      else begin
        chk("b2b_vld", out_valid, 1);
        chk("b2b_y", y, 32'hA0 + n - 2);
      end
      if (n < 5) begin
        in_valid = 1'b1; a = 8'(n); b = 8'hA0; op = 3'b010;
      end else in_valid = 1'b0;
    end

    // Backpressure
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_in_ready0", in_ready, 1);
    in_valid = 1'b1; a = 8'h55; b = 8'h0F; op = 3'b000;
    @(negedge clk);
    chk("bp_in_ready1", in_ready, 1);
    chk("bp_vld_early", out_valid, 0);
    op = 3'b001;
    @(negedge clk);
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_vld", out_valid, 1);
    chk("bp_y", y, 8'h5F);
    op = 3'b010;
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_vld", out_valid, 1);
      chk("bp_hold_y", y, 8'h5F);
      chk("bp_hold_flags", mflg, 3'b000);
    end
    @(negedge clk);
    chk("bp_pre_release_y", y, 8'h5F);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    @(negedge clk);
    chk("bp_out2_vld", out_valid, 1);
    chk("bp_out2_y", y, 8'h05);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out3_vld", out_valid, 1);
    chk("bp_out3_y", y, 8'h5A);
    @(negedge clk);
    chk("bp_drained", out_valid, 0);
    chk("idle_hold_y", y, 8'h5A);

    // Reset with two beats in flight
    @(negedge clk);
    in_valid = 1'b1; a = 8'hFF; b = 8'h00; op = 3'b000;
    @(negedge clk);
    a = 8'h81;
    @(negedge clk);
    chk("mid_y_before", y, 8'hFF);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_flags", mflg, 0);
    chk("mid_rst_ready", in_ready, 1);
`ifdef LOGIC_UNIT_OP_COUNT_EN
    chk("mid_rst_count", cnt_m, 0);
`endif
    repeat (4) begin
      @(negedge clk);
      chk("mid_no_stale", out_valid, 0);
    end

    // Sweep: STAGES=1/WIDTH=1 and STAGES=4/WIDTH=32, fixed latency with out_ready=1
    for (int n = 0; n < N + 5; n++) begin
      logic [31:0] r;
      logic        vld;
      @(negedge clk);
      chk("s1_in_ready", i1_ready, 1);
      chk("s4_in_ready", i4_ready, 1);
      if (n >= 1) begin
        chk("s1_vld", o1_valid, hv[n-1]);
        if (hv[n-1]) begin
          chk("s1_y", y1, e1[n-1]);
          chk("s1_flags", {n1, p1, z1}, f1[n-1]);
        end
      end else chk("s1_vld_start", o1_valid, 0);
      if (n >= 4) begin
        chk("s4_vld", o4_valid, hv[n-4]);
        if (hv[n-4]) begin
          chk("s4_y", y4, e32[n-4]);
          chk("s4_flags", {n4, p4, z4}, f32[n-4]);
        end
      end else chk("s4_vld_start", o4_valid, 0);
      if (o1_valid) xfer1++;
      if (o4_valid) xfer4++;
      if (n < N) begin
        vld = (n < 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
        case (n)
          0: begin sop = 3'b110; sa = 32'h1234_5678; sb = 32'hFFFF_FFFF; end
          1: begin sop = 3'b111; sa = 32'hDEAD_BEEF; sb = 32'h0F0F_00F1; end
          2: begin sop = 3'b110; sa = 32'hFFFF_FFFF; sb = 32'h0000_0000; end
          3: begin sop = 3'b111; sa = 32'h0000_0000; sb = 32'h8000_0000; end
          default: begin sop = 3'($urandom_range(0, 7)); sa = $urandom; sb = $urandom; end
        endcase
        sv = vld;
        hv[n] = vld;
        r = ref_op(sop, sa, sb);
        e32[n] = r;
        f32[n] = {r[31], ^r, (r == 32'd0)};
        e1[n]  = r[0];
        f1[n]  = {r[0], r[0], ~r[0]};
      end else begin
        sv = 1'b0;
        hv[n] = 1'b0;
      end
    end
    // Hand-computed directed sweep results
    chk("s4_op110_ref", e32[0], 32'hEDCB_A987);
    chk("s4_op111_ref", e32[1], 32'h0F0F_00F1);
    @(negedge clk);
`ifdef LOGIC_UNIT_OP_COUNT_EN
    chk("s1_op_count", cnt_1, 16'(xfer1));
    chk("s4_op_count", cnt_4, 16'(xfer4));
`endif
    chk("s1_idle", o1_valid, 0);
    chk("s4_idle", o4_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
